dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported 32-word data memory between the processor load/store path (port 0) and a secondary requester such as a loader or debug port (port 1). It issues at most one memory access per cycle and drives the memory's address, write data and write/read enables. It returns registered read data to the granted requester one cycle later. It supports locked bursts so one requester can perform an uninterrupted read-modify-write or block transfer.

---
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the load/store
// path (port 0) and a secondary requester (port 1), one access per cycle.
// Supports locked bursts of up to MAX_LOCK accesses and returns registered
// read data one cycle after the grant.
// Optional build macro DMEM_ARB_FIXED_PRI_EN: port 0 always wins contention
// in IDLE instead of round-robin.
module dmem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  count_inc;
  logic              gnt0, gnt1;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata_q;

  assign count_inc = count_q + 1'b1;

  // Arbitration: decide this cycle's grant and the next owner/pointer/count
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    count_d = count_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (r0_req && r1_req) begin
`ifdef DMEM_ARB_FIXED_PRI_EN
          gnt0 = 1'b1;
`else
          if (last_q) gnt0 = 1'b1;
          else        gnt1 = 1'b1;
`endif
        end else if (r0_req) begin
          gnt0 = 1'b1;
        end else if (r1_req) begin
          gnt1 = 1'b1;
        end
        // A locked first access opens a burst unless the burst limit is one
        if (gnt0) begin
          last_d = 1'b0;
          if (r0_lock && (MAX_LOCK > 1)) begin
            state_d = OWN0;
            count_d = CNT_W'(1);
          end
        end else if (gnt1) begin
          last_d = 1'b1;
          if (r1_lock && (MAX_LOCK > 1)) begin
            state_d = OWN1;
            count_d = CNT_W'(1);
          end
        end
      end
      OWN0: begin
        if (r0_req) begin
          gnt0   = 1'b1;
          last_d = 1'b0;
          if (r0_lock && (count_inc < CNT_W'(MAX_LOCK))) begin
            count_d = count_inc;
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
        end else begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      OWN1: begin
        if (r1_req) begin
          gnt1   = 1'b1;
          last_d = 1'b1;
          if (r1_lock && (count_inc < CNT_W'(MAX_LOCK))) begin
            count_d = count_inc;
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
        end else begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Grants are held low while reset is asserted so the memory sees no access
  assign r0_gnt = gnt0 & rst_n;
  assign r1_gnt = gnt1 & rst_n;

  // Memory-side mux: the granted port drives the memory, otherwise all zero
  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    if (r0_gnt) begin
      mem_address    = r0_addr;
      mem_write_data = r0_wdata;
      mem_write      = r0_we;
      mem_read       = ~r0_we;
    end else if (r1_gnt) begin
      mem_address    = r1_addr;
      mem_write_data = r1_wdata;
      mem_write      = r1_we;
      mem_read       = ~r1_we;
    end
  end

  // Arbiter state register; reset aborts any burst in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Read return: capture memory data on the grant edge, flag the reader next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid0_q <= r0_gnt & ~r0_we;
      rvalid1_q <= r1_gnt & ~r1_we;
      if (mem_read) rdata_q <= mem_read_data;
    end
  end

  assign r0_rvalid = rvalid0_q;
  assign r1_rvalid = rvalid1_q;
  assign r0_rdata  = rdata_q;
  assign r1_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// 32-word behavioural memory (combinational read, write on clock edge).
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0_req, r0_we, r0_lock;
  logic [4:0]  r0_addr;
  logic [31:0] r0_wdata;
  logic        r1_req, r1_we, r1_lock;
  logic [4:0]  r1_addr;
  logic [31:0] r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic [4:0]  mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write, mem_read;
  logic [31:0] mem_read_data;

  logic [31:0] mem [32];
  int          errors = 0;
  int          checks = 0;

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_write_data;
  end

  // Advance one cycle, drive both ports just after the edge, let logic settle
  task automatic applyStimulus(
    input logic q0, input logic w0, input logic k0, input logic [4:0] a0, input logic [31:0] d0,
    input logic q1, input logic w1, input logic k1, input logic [4:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    r0_req = q0; r0_we = w0; r0_lock = k0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_lock = k1; r1_addr = a1; r1_wdata = d1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkGrant(input string tag, input logic g0, input logic g1);
    checkOutput({tag, ".r0_gnt"}, {31'd0, r0_gnt}, {31'd0, g0});
    checkOutput({tag, ".r1_gnt"}, {31'd0, r1_gnt}, {31'd0, g1});
  endtask

  task automatic checkMem(input string tag, input logic rd, input logic wr,
                          input logic [4:0] a, input logic [31:0] d);
    checkOutput({tag, ".mem_read"}, {31'd0, mem_read}, {31'd0, rd});
    checkOutput({tag, ".mem_write"}, {31'd0, mem_write}, {31'd0, wr});
    checkOutput({tag, ".mem_address"}, {27'd0, mem_address}, {27'd0, a});
    checkOutput({tag, ".mem_write_data"}, mem_write_data, d);
  endtask

  task automatic checkRead(input string tag, input logic v0, input logic v1, input logic [31:0] d);
    checkOutput({tag, ".r0_rvalid"}, {31'd0, r0_rvalid}, {31'd0, v0});
    checkOutput({tag, ".r1_rvalid"}, {31'd0, r1_rvalid}, {31'd0, v1});
    checkOutput({tag, ".r0_rdata"}, r0_rdata, d);
    checkOutput({tag, ".r1_rdata"}, r1_rdata, d);
  endtask

  // Directed sequence
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 | i;
    rst_n = 1'b0;
    r0_req = 1'b1; r0_we = 1'b0; r0_lock = 1'b0; r0_addr = 5'd3; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_lock = 1'b0; r1_addr = '0;   r1_wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    checkGrant("reset", 1'b0, 1'b0);
    checkMem("reset", 1'b0, 1'b0, 5'd0, 32'd0);
    checkRead("reset", 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0_req = 1'b0;

    // Contention from reset: grants alternate 0,1,0,1
    applyStimulus(1, 0, 0, 5'd1, 0, 1, 0, 0, 5'd2, 0);
    checkGrant("cont1", 1'b1, 1'b0);
    checkMem("cont1", 1'b1, 1'b0, 5'd1, 32'd0);
    applyStimulus(1, 0, 0, 5'd1, 0, 1, 0, 0, 5'd2, 0);
    checkGrant("cont2", 1'b0, 1'b1);
    checkMem("cont2", 1'b1, 1'b0, 5'd2, 32'd0);
    checkRead("cont2", 1'b1, 1'b0, 32'hA5A5_0001);
    applyStimulus(1, 0, 0, 5'd1, 0, 1, 0, 0, 5'd2, 0);
    checkGrant("cont3", 1'b1, 1'b0);
    checkRead("cont3", 1'b0, 1'b1, 32'hA5A5_0002);
    applyStimulus(1, 0, 0, 5'd1, 0, 1, 0, 0, 5'd2, 0);
    checkGrant("cont4", 1'b0, 1'b1);
    checkRead("cont4", 1'b1, 1'b0, 32'hA5A5_0001);

    // Single read of address 5 by port 0
    applyStimulus(1, 0, 0, 5'd5, 0, 0, 0, 0, 5'd0, 0);
    checkGrant("single", 1'b1, 1'b0);
    checkMem("single", 1'b1, 1'b0, 5'd5, 32'd0);
    checkRead("single", 1'b0, 1'b1, 32'hA5A5_0002);
    applyStimulus(0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
    checkGrant("idle1", 1'b0, 1'b0);
    checkMem("idle1", 1'b0, 1'b0, 5'd0, 32'd0);
    checkRead("idle1", 1'b1, 1'b0, 32'hA5A5_0005);
    applyStimulus(0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
    checkRead("hold", 1'b0, 1'b0, 32'hA5A5_0005);

    // Write then read on port 1, address 31
    applyStimulus(0, 0, 0, 5'd0, 0, 1, 1, 0, 5'd31, 32'hDEAD_BEEF);
    checkGrant("wr31", 1'b0, 1'b1);
    checkMem("wr31", 1'b0, 1'b1, 5'd31, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd31, 0);
    checkGrant("rd31", 1'b0, 1'b1);
    checkRead("rd31", 1'b0, 1'b0, 32'hA5A5_0005);
    applyStimulus(0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
    checkRead("rd31data", 1'b0, 1'b1, 32'hDEAD_BEEF);

    // Read then write on port 0, address 7: read returns pre-write value
    applyStimulus(1, 0, 0, 5'd7, 0, 0, 0, 0, 5'd0, 0);
    checkGrant("rmw_rd", 1'b1, 1'b0);
    applyStimulus(1, 1, 0, 5'd7, 32'h0BAD_F00D, 0, 0, 0, 5'd0, 0);
    checkMem("rmw_wr", 1'b0, 1'b1, 5'd7, 32'h0BAD_F00D);
    checkRead("rmw_old", 1'b1, 1'b0, 32'hA5A5_0007);
    applyStimulus(1, 0, 0, 5'd7, 0, 0, 0, 0, 5'd0, 0);
    checkRead("rmw_wrnv", 1'b0, 1'b0, 32'hA5A5_0007);
    applyStimulus(0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
    checkRead("rmw_new", 1'b1, 1'b0, 32'h0BAD_F00D);

    // Port 1 locked burst (3 locked + final unlocked) while port 0 keeps asking
    applyStimulus(1, 0, 0, 5'd0, 0, 1, 0, 1, 5'd10, 0);
    checkGrant("lock1", 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 5'd0, 0, 1, 0, 1, 5'd11, 0);
    checkGrant("lock2", 1'b0, 1'b1);
    checkRead("lock2", 1'b0, 1'b1, 32'hA5A5_000A);
    applyStimulus(1, 0, 0, 5'd0, 0, 1, 0, 1, 5'd12, 0);
    checkGrant("lock3", 1'b0, 1'b1);
    checkRead("lock3", 1'b0, 1'b1, 32'hA5A5_000B);
    applyStimulus(1, 0, 0, 5'd0, 0, 1, 0, 0, 5'd13, 0);
    checkGrant("lockfin", 1'b0, 1'b1);
    checkMem("lockfin", 1'b1, 1'b0, 5'd13, 32'd0);
    applyStimulus(1, 0, 0, 5'd0, 0, 1, 0, 0, 5'd13, 0);
    checkGrant("unlock", 1'b1, 1'b0);
    checkRead("unlock", 1'b0, 1'b1, 32'hA5A5_000D);
    applyStimulus(0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd14, 0);
    checkGrant("after", 1'b0, 1'b1);
    checkRead("after", 1'b1, 1'b0, 32'hA5A5_0000);

    // Port 0 holds lock indefinitely: exactly MAX_LOCK grants, then port 1
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1, 0, 1, 5'(16 + k), 0, 1, 0, 0, 5'd20, 0);
      checkGrant($sformatf("max%0d", k), 1'b1, 1'b0);
      if (k == 1) checkRead("max1", 1'b0, 1'b1, 32'hA5A5_000E);
      else        checkRead($sformatf("max%0d", k), 1'b1, 1'b0, 32'hA5A5_0000 + 32'(15 + k));
    end
    applyStimulus(1, 0, 1, 5'd25, 0, 1, 0, 0, 5'd20, 0);
    checkGrant("maxexit", 1'b0, 1'b1);
    checkMem("maxexit", 1'b1, 1'b0, 5'd20, 32'd0);
    checkRead("maxexit", 1'b1, 1'b0, 32'hA5A5_0018);

    // Re-enter OWN0, then reset mid-burst
    applyStimulus(1, 0, 1, 5'd26, 0, 1, 0, 0, 5'd20, 0);
    checkGrant("own0a", 1'b1, 1'b0);
    applyStimulus(1, 0, 1, 5'd27, 0, 1, 0, 0, 5'd20, 0);
    checkGrant("own0b", 1'b1, 1'b0);
    checkRead("own0b", 1'b1, 1'b0, 32'hA5A5_001A);
    rst_n = 1'b0;
    #1;
    checkGrant("midrst", 1'b0, 1'b0);
    checkMem("midrst", 1'b0, 1'b0, 5'd0, 32'd0);
    checkRead("midrst", 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0_lock = 1'b0; r0_addr = 5'd3; r1_addr = 5'd4;
    #1;
    checkGrant("postrst1", 1'b1, 1'b0);
    checkMem("postrst1", 1'b1, 1'b0, 5'd3, 32'd0);
    applyStimulus(1, 0, 0, 5'd3, 0, 1, 0, 0, 5'd4, 0);
    checkGrant("postrst2", 1'b0, 1'b1);
    checkRead("postrst2", 1'b1, 1'b0, 32'hA5A5_0003);

    applyStimulus(0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
